// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard sequencer.
// PCSrc encodings driven by Control and the hardwired-zero register index.
package pipe_hazard_ctrl_pkg;

    localparam logic [2:0] PCSRC_SEQ = 3'd0;
    localparam logic [2:0] PCSRC_BR  = 3'd1;
    localparam logic [2:0] PCSRC_J   = 3'd2;
    localparam logic [2:0] PCSRC_JR  = 3'd3;
    localparam logic [2:0] PCSRC_IRQ = 3'd4;
    localparam logic [2:0] PCSRC_EXC = 3'd5;

    localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_irq_sync_latch.sv
// Interrupt front end: synchroniser, rising-edge detect, pending latch,
// defer counter and sticky irq_late.
// Ports: clk, reset (sync, high), irq_in (async level), irq_take (IRQ accepted
// this cycle), pending (request outstanding), irq_late (waited too long).
module irq_sync_latch #(
    parameter int SYNC_STAGES = 2,
    parameter int DEFER_MAX   = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    input  logic irq_take,
    output logic pending,
    output logic irq_late
);

    localparam int DW = $clog2(DEFER_MAX + 2);
    localparam logic [DW-1:0] DEFER_LIM = DW'(DEFER_MAX);
    localparam logic [DW-1:0] DEFER_SAT = DW'(DEFER_MAX + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl_d;
    logic                   r_pending;
    logic                   r_late;
    logic [DW-1:0]          r_defer;

    logic                   w_rise;
    logic [DW-1:0]          w_defer_nxt;

    assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_lvl_d;
    assign pending  = r_pending;
    assign irq_late = r_late;

    // Counter restarts whenever the request is taken; a coincident new edge
    // keeps pending set and begins a fresh wait.
    always_comb begin
        w_defer_nxt = r_defer;
        if (irq_take) begin
            w_defer_nxt = '0;
        end else if (r_pending && r_defer != DEFER_SAT) begin
            w_defer_nxt = r_defer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '0;
            r_lvl_d   <= 1'b0;
            r_pending <= 1'b0;
            r_defer   <= '0;
            r_late    <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], irq_in};
            r_lvl_d <= r_sync[SYNC_STAGES-1];
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (irq_take) begin
                r_pending <= 1'b0;
            end
            r_defer <= w_defer_nxt;
            if (w_defer_nxt > DEFER_LIM) begin
                r_late <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: PC/IF-ID enables, IF/ID and ID/EX flushes,
// safe-boundary IRQ entry and stall/flush counters.
// Ports: pipeline hazard inputs (id_*, ex_*), irq_in/ker, control outputs
// (irq_out, pc_wr, ifid_wr, ifid_flush, idex_flush), irq_late, counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32,
    parameter int DEFER_MAX   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq_in,
    input  logic             ker,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [2:0]       id_pcsrc,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_br_taken,
    output logic             irq_out,
    output logic             pc_wr,
    output logic             ifid_wr,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             irq_late,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             r_id_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_pending;
    logic w_lu;
    logic w_irq_ok;
    logic w_redirect;
    logic w_stall;

    assign w_lu = ex_memrd && (ex_wreg != REG_ZERO) &&
                  ((ex_wreg == id_rs) ||
                   (id_uses_rt && (ex_wreg == id_rt)));

    // IRQ only enters on a real instruction that is not about to stall.
    assign w_irq_ok   = w_pending & ~ker & r_id_valid & ~w_lu;
    assign w_redirect = (id_pcsrc == PCSRC_J) ||
                        (id_pcsrc == PCSRC_JR) ||
                        (id_pcsrc == PCSRC_EXC);

    always_comb begin
        irq_out    = 1'b0;
        pc_wr      = 1'b1;
        ifid_wr    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        w_stall    = 1'b0;
        if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_irq_ok) begin
            irq_out    = 1'b1;
            ifid_flush = 1'b1;
        end else if (w_lu) begin
            pc_wr      = 1'b0;
            ifid_wr    = 1'b0;
            idex_flush = 1'b1;
            w_stall    = 1'b1;
        end else if (w_redirect) begin
            ifid_flush = 1'b1;
        end
    end

    irq_sync_latch #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEFER_MAX   (DEFER_MAX)
    ) u_irq (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .irq_take (irq_out),
        .pending  (w_pending),
        .irq_late (irq_late)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_valid  <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (ifid_flush) begin
                r_id_valid <= 1'b0;
            end else if (ifid_wr) begin
                r_id_valid <= 1'b1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (ifid_flush) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
